// File: rtl/act_xmem_loader_pkg.sv
// Shared definitions for the X_MEM activation loader: FSM state encoding,
// default word/address widths, tile-half width and a lane-sum helper used
// by the optional running checksum (ACT_LOADER_CKSUM_EN).
package act_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 11;
  localparam int TILE_W = 16;

  // Sum of the eight unsigned 4-bit lanes of one X_MEM word.
  function automatic logic [15:0] lane_sum(input logic [WORD_W-1:0] w);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < WORD_W / 4; i++) begin
      s = s + 16'(w[4*i +: 4]);
    end
    return s;
  endfunction

endpackage

// File: rtl/act_xmem_loader_interleave.sv
// Combinational 2-bit activation packer: lane i of the output word carries
// tile1's 2-bit activation i in its MSB pair and tile0's in its LSB pair.
module act_2b_interleave
  import act_loader_pkg::*;
(
  input  logic [TILE_W-1:0] tile0_i,
  input  logic [TILE_W-1:0] tile1_i,
  output logic [WORD_W-1:0] word_o
);

  for (genvar i = 0; i < WORD_W / 4; i++) begin : g_lane
    assign word_o[4*i+3:4*i] = {tile1_i[2*i+1:2*i], tile0_i[2*i+1:2*i]};
  end

endmodule

// File: rtl/act_xmem_loader.sv
// X_MEM write-port feeder. Takes a valid/ready stream of activation words for
// one batch and issues CEN/WEN/A/D writes one cycle after each handshake,
// optionally interleaving two 16-bit tiles in 2-bit activation mode.
// Optional feature: define ACT_LOADER_CKSUM_EN to add a running 16-bit lane
// checksum output (cksum) over all words written in the batch.
module act_xmem_loader
  import act_loader_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int addr_w = ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                act_2b_mode,
  input  logic                start,
  input  logic [addr_w-1:0]   base_addr,
  input  logic [addr_w-1:0]   num_words,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bw*row-1:0]   in_data,
  output logic                CEN_xmem,
  output logic                WEN_xmem,
  output logic [addr_w-1:0]   A_xmem,
  output logic [bw*row-1:0]   D_xmem,
  output logic                busy,
  output logic                done
`ifdef ACT_LOADER_CKSUM_EN
  ,
  output logic [15:0]         cksum
`endif
);

  localparam int DW = bw * row;

  state_e              state_q;
  logic [addr_w-1:0]   cnt_q;
  logic [addr_w-1:0]   base_q;
  logic [addr_w-1:0]   num_q;
  logic                mode_q;
  logic                cen_q;
  logic                wen_q;
  logic [addr_w-1:0]   a_q;
  logic [DW-1:0]       d_q;
  logic                done_q;

  logic [DW-1:0]       il_word;
  logic [DW-1:0]       packed_word;
  logic                hs;

  act_2b_interleave u_interleave (
    .tile0_i (in_data[TILE_W-1:0]),
    .tile1_i (in_data[WORD_W-1:TILE_W]),
    .word_o  (il_word)
  );

  // Mode is the copy latched at start, so mid-batch toggles have no effect.
  assign packed_word = mode_q ? il_word : in_data;

  // Ready depends on state alone; no combinational path from in_valid.
  assign in_ready = (state_q == ST_LOAD);
  assign hs       = in_valid && (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign CEN_xmem = cen_q;
  assign WEN_xmem = wen_q;
  assign A_xmem   = a_q;
  assign D_xmem   = d_q;

  // Batch FSM with registered write-port outputs; each write lands the cycle
  // after its handshake, and done is raised together with the final write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      num_q   <= '0;
      mode_q  <= 1'b0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      a_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      // Idle the write port unless this cycle carries a handshake; A/D hold.
      cen_q  <= 1'b1;
      wen_q  <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            num_q  <= num_words;
            mode_q <= act_2b_mode;
            cnt_q  <= '0;
            if (num_words == '0) begin
              // Empty batch: report completion without touching memory.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (hs) begin
            cen_q <= 1'b0;
            wen_q <= 1'b0;
            a_q   <= base_q + cnt_q;  // wraps naturally at 2^addr_w
            d_q   <= packed_word;
            cnt_q <= cnt_q + addr_w'(1);
            if (cnt_q == num_q - addr_w'(1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ACT_LOADER_CKSUM_EN
  logic [15:0] cksum_q;

  assign cksum = cksum_q;

  // Running lane checksum of written words; updated on the same edge as the
  // write register so the total is complete in the done cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cksum_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      cksum_q <= '0;
    end else if (hs) begin
      cksum_q <= cksum_q + lane_sum(packed_word);
    end
  end
`endif

endmodule

// File: tb/tb_act_xmem_loader.sv
// Self-checking bench for act_xmem_loader: directed scenarios plus random
// batches, checked against a transaction-level model of the write stream.
module tb_act_xmem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        act_2b_mode;
  logic        start;
  logic [10:0] base_addr;
  logic [10:0] num_words;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        CEN_xmem;
  logic        WEN_xmem;
  logic [10:0] A_xmem;
  logic [31:0] D_xmem;
  logic        busy;
  logic        done;
`ifdef ACT_LOADER_CKSUM_EN
  logic [15:0] cksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] words [64];
  int          vpat  [16];

  always #5 clk = ~clk;

  act_xmem_loader dut (
    .clk         (clk),
    .reset       (reset),
    .act_2b_mode (act_2b_mode),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .CEN_xmem    (CEN_xmem),
    .WEN_xmem    (WEN_xmem),
    .A_xmem      (A_xmem),
    .D_xmem      (D_xmem),
    .busy        (busy),
    .done        (done)
`ifdef ACT_LOADER_CKSUM_EN
    ,
    .cksum       (cksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Output bit b sits in lane b/4; lane bits 0..1 come from tile0, 2..3 from tile1.
  function automatic logic [31:0] model_pack(input bit mode, input logic [31:0] w);
    logic [31:0] r;
    int lane, pos;
    if (!mode) return w;
    for (int b = 0; b < 32; b++) begin
      lane = b / 4;
      pos  = b % 4;
      if (pos < 2) r[b] = w[2*lane + pos];
      else         r[b] = w[16 + 2*lane + pos - 2];
    end
    return r;
  endfunction

  function automatic logic [15:0] model_lanes(input logic [31:0] w);
    int s = 0;
    for (int i = 0; i < 8; i++) s += (w >> (4 * i)) & 32'hF;
    return 16'(s);
  endfunction

  // vmode: 0 = valid always high, 1 = random stalls, 2 = follow vpat[].
  task automatic run_batch(input bit mode, input int base, input int n,
                           input int vmode, input string tag);
    int          hs;
    int          k;
    bit          prev_hs;
    bit          fin;
    bit          exp_done;
    bit          v;
    logic [10:0] exp_a;
    logic [31:0] exp_d;
    logic [15:0] exp_ck;
    hs = 0; k = 0; prev_hs = 0; fin = 0; exp_ck = '0; exp_a = '0; exp_d = '0;
    act_2b_mode = mode;
    base_addr   = 11'(base);
    num_words   = 11'(n);
    in_valid    = 1'b0;
    start       = 1'b1;
    step();
    start = 1'b0;
    while (!fin && k < 300) begin
      exp_done = (n == 0 && k == 0) || (prev_hs && hs == n);
      chk({tag, ":cen"}, CEN_xmem, prev_hs ? 0 : 1);
      chk({tag, ":wen"}, WEN_xmem, prev_hs ? 0 : 1);
      if (prev_hs) begin
        chk({tag, ":addr"}, A_xmem, exp_a);
        chk({tag, ":data"}, D_xmem, exp_d);
      end
      chk({tag, ":ready"}, in_ready, (hs < n) ? 1 : 0);
      chk({tag, ":busy"}, busy, 1);
      chk({tag, ":done"}, done, exp_done);
      if (exp_done) begin
`ifdef ACT_LOADER_CKSUM_EN
        chk({tag, ":cksum"}, cksum, exp_ck);
`endif
        fin = 1;
      end else begin
        case (vmode)
          0:       v = 1'b1;
          1:       v = ($urandom_range(0, 2) != 0);
          default: v = (vpat[k % 16] != 0);
        endcase
        in_valid = v;
        in_data  = v ? words[hs] : $urandom;
        // Mid-batch noise on inputs that must be ignored while busy.
        start       = $urandom_range(0, 1) != 0;
        act_2b_mode = $urandom_range(0, 1) != 0;
        base_addr   = 11'($urandom);
        num_words   = 11'($urandom);
        prev_hs = v && (hs < n);
        if (prev_hs) begin
          exp_a  = 11'(base + hs);
          exp_d  = model_pack(mode, words[hs]);
          exp_ck = exp_ck + model_lanes(exp_d);
          hs++;
        end
        step();
        k++;
      end
    end
    if (!fin) chk({tag, ":timeout"}, 0, 1);
    start    = 1'b0;
    in_valid = 1'b0;
    step();
    chk({tag, ":idle_busy"}, busy, 0);
    chk({tag, ":idle_done"}, done, 0);
    chk({tag, ":idle_cen"}, CEN_xmem, 1);
  endtask

  initial begin
    int n;
    reset       = 1'b0;
    act_2b_mode = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    num_words   = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    step();
    step();
    chk("rst:cen", CEN_xmem, 1);
    chk("rst:wen", WEN_xmem, 1);
    chk("rst:addr", A_xmem, 0);
    chk("rst:data", D_xmem, 0);
    chk("rst:ready", in_ready, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    reset = 1'b1;
    step();

    // 4-bit pass-through, back-to-back, words 1..9.
    for (int i = 0; i < 9; i++) words[i] = 32'(i + 1);
    run_batch(1'b0, 0, 9, 0, "seq4b");

    // 2-bit interleave, single words.
    words[0] = 32'h0000_FFFF;
    run_batch(1'b1, 100, 1, 0, "il_t0");
    chk("il_t0:const", D_xmem, 32'h3333_3333);
    words[0] = 32'hFFFF_0000;
    run_batch(1'b1, 101, 1, 0, "il_t1");
    chk("il_t1:const", D_xmem, 32'hCCCC_CCCC);

    // Stall pattern 1,0,0,1,1.
    vpat = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_batch(1'b0, 500, 3, 2, "stall");

    // Address wrap, then empty batch.
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_batch(1'b0, 2046, 3, 0, "wrap");
    chk("wrap:last_addr", A_xmem, 0);
    run_batch(1'b0, 77, 0, 0, "zero");

    // Reset in the middle of a 9-word batch.
    for (int i = 0; i < 9; i++) words[i] = $urandom;
    act_2b_mode = 1'b0;
    base_addr   = 11'd300;
    num_words   = 11'd9;
    start       = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      step();
    end
    chk("mid:pre_cen", CEN_xmem, 0);
    chk("mid:pre_addr", A_xmem, 303);
    reset = 1'b0;
    #1;
    chk("mid:cen", CEN_xmem, 1);
    chk("mid:wen", WEN_xmem, 1);
    chk("mid:addr", A_xmem, 0);
    chk("mid:data", D_xmem, 0);
    chk("mid:ready", in_ready, 0);
    chk("mid:busy", busy, 0);
    chk("mid:done", done, 0);
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid:after_busy", busy, 0);
    chk("mid:after_cen", CEN_xmem, 1);
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    run_batch(1'b1, 10, 4, 1, "post_rst");

    // Random batches, random stalls, random mode.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      run_batch($urandom_range(0, 1) != 0,
                (r == 0) ? 2040 : int'($urandom_range(0, 2047)), n, 1, "rnd");
    end

`ifdef ACT_LOADER_CKSUM_EN
    words[0] = 32'h1111_1111;
    words[1] = 32'hFFFF_FFFF;
    run_batch(1'b0, 0, 2, 0, "cks");
    chk("cks:hold", cksum, 16'h0080);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
